// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the NOP/bubble instruction and the load-use match helper.
package hazard_pkg;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LU_STALL  = 2'd1;
  localparam logic [1:0] ST_BUSY_HOLD = 2'd2;

  localparam int unsigned CNT_W = 3;

  // addi x0, x0, 0 -- what a flushed pipeline register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic lu_hit_f(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return mem_read && (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter32.sv
// 32-bit saturating event counter used for the hazard performance counters
// (instantiated only when HAZARD_PERF_CNT_EN is defined).
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'h0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/redirect generation for the 5-stage pipeline.
// Optional performance counters: define HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_mem_read_en_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_redirect_target_i,
  input  logic        dmem_busy_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        ex_mem_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_redirect_target_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_flush_count_o
`endif
);

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_USE_CYCLES - 1);
  localparam bit               LU_MULTI  = (LOAD_USE_CYCLES > 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sv_state_q, sv_state_d;
  logic [CNT_W-1:0] sv_cnt_q, sv_cnt_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;

  logic             lu_hit;
  logic             release_s;
  logic [1:0]       eff_state;
  logic [CNT_W-1:0] eff_cnt;

  logic pc_stall_s, if_id_stall_s, id_ex_stall_s, ex_mem_stall_s;
  logic if_id_flush_s, id_ex_flush_s, redirect_s;
  logic [31:0] redirect_tgt_s;

  assign lu_hit = lu_hit_f(ex_mem_read_en_i, ex_rd_addr_i, id_rs1_addr_i,
                           id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i);

  // Leaving BUSY_HOLD resumes the remembered state within the same cycle.
  assign release_s = (state_q == ST_BUSY_HOLD) && !dmem_busy_i;
  assign eff_state = release_s ? sv_state_q : state_q;
  assign eff_cnt   = release_s ? sv_cnt_q   : cnt_q;

  // Strobe and next-state decode, priority busy > pending > redirect > load-use.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sv_state_d     = sv_state_q;
    sv_cnt_d       = sv_cnt_q;
    pend_d         = pend_q;
    pend_tgt_d     = pend_tgt_q;
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    redirect_s     = 1'b0;
    redirect_tgt_s = 32'h0;

    if (dmem_busy_i) begin
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_stall_s = 1'b1;
      state_d        = ST_BUSY_HOLD;
      if (state_q != ST_BUSY_HOLD) begin
        sv_state_d = state_q;
        sv_cnt_d   = cnt_q;
      end else begin
        sv_state_d = sv_state_q;
        sv_cnt_d   = sv_cnt_q;
      end
      if (ex_redirect_i && !pend_q) begin
        pend_d     = 1'b1;
        pend_tgt_d = ex_redirect_target_i;
      end else begin
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
      end
    end else if (release_s && pend_q) begin
      redirect_s     = 1'b1;
      redirect_tgt_s = pend_tgt_q;
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      pend_d         = 1'b0;
      state_d        = ST_RUN;
      cnt_d          = {CNT_W{1'b0}};
      sv_state_d     = ST_RUN;
      sv_cnt_d       = {CNT_W{1'b0}};
    end else if (ex_redirect_i) begin
      redirect_s     = 1'b1;
      redirect_tgt_s = ex_redirect_target_i;
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      state_d        = ST_RUN;
      cnt_d          = {CNT_W{1'b0}};
    end else begin
      case (eff_state)
        ST_LU_STALL: begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          id_ex_flush_s = 1'b1;
          if (eff_cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_RUN;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ST_LU_STALL;
            cnt_d   = eff_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          if (lu_hit) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            id_ex_flush_s = 1'b1;
            if (LU_MULTI) begin
              state_d = ST_LU_STALL;
              cnt_d   = LU_RELOAD;
            end else begin
              state_d = ST_RUN;
              cnt_d   = {CNT_W{1'b0}};
            end
          end else begin
            state_d = ST_RUN;
            cnt_d   = {CNT_W{1'b0}};
          end
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= {CNT_W{1'b0}};
      sv_state_q <= ST_RUN;
      sv_cnt_q   <= {CNT_W{1'b0}};
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sv_state_q <= sv_state_d;
      sv_cnt_q   <= sv_cnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Strobes are combinational, so they must be masked while reset is held.
  assign pc_stall_o           = rst_n & pc_stall_s;
  assign if_id_stall_o        = rst_n & if_id_stall_s;
  assign id_ex_stall_o        = rst_n & id_ex_stall_s;
  assign ex_mem_stall_o       = rst_n & ex_mem_stall_s;
  assign if_id_flush_o        = rst_n & if_id_flush_s;
  assign id_ex_flush_o        = rst_n & id_ex_flush_s;
  assign pc_redirect_o        = rst_n & redirect_s;
  assign pc_redirect_target_o = rst_n ? redirect_tgt_s : 32'h0;

`ifdef HAZARD_PERF_CNT_EN
  sat_counter32 u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (pc_stall_o),
    .count_o (perf_stall_cycles_o)
  );

  sat_counter32 u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (id_ex_flush_o),
    .count_o (perf_flush_count_o)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_USE_CYCLES 1 and 3)
// share the same stimulus; outputs are checked at the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, mem_rd, redir, busy;
  logic [31:0] redir_tgt;

  logic        a_pcs, a_ifs, a_ids, a_exs, a_iff, a_idf, a_rd;
  logic [31:0] a_tgt;
  logic        b_pcs, b_ifs, b_ids, b_exs, b_iff, b_idf, b_rd;
  logic [31:0] b_tgt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_pst, a_pfl, b_pst, b_pfl;
`endif

  int n_vec = 0;
  int n_err = 0;

  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, redirect}
  localparam logic [6:0] NONE = 7'b000_0000;
  localparam logic [6:0] BUB  = 7'b110_0010;
  localparam logic [6:0] BSY  = 7'b111_1000;
  localparam logic [6:0] RDR  = 7'b000_0111;

  wire [6:0] a_str = {a_pcs, a_ifs, a_ids, a_exs, a_iff, a_idf, a_rd};
  wire [6:0] b_str = {b_pcs, b_ifs, b_ids, b_exs, b_iff, b_idf, b_rd};

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd), .ex_mem_read_en_i(mem_rd),
    .ex_redirect_i(redir), .ex_redirect_target_i(redir_tgt),
    .dmem_busy_i(busy),
    .pc_stall_o(a_pcs), .if_id_stall_o(a_ifs), .id_ex_stall_o(a_ids),
    .ex_mem_stall_o(a_exs), .if_id_flush_o(a_iff), .id_ex_flush_o(a_idf),
    .pc_redirect_o(a_rd), .pc_redirect_target_o(a_tgt)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles_o(a_pst), .perf_flush_count_o(a_pfl)
`endif
  );

  hazard_ctrl #(.LOAD_USE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd), .ex_mem_read_en_i(mem_rd),
    .ex_redirect_i(redir), .ex_redirect_target_i(redir_tgt),
    .dmem_busy_i(busy),
    .pc_stall_o(b_pcs), .if_id_stall_o(b_ifs), .id_ex_stall_o(b_ids),
    .ex_mem_stall_o(b_exs), .if_id_flush_o(b_iff), .id_ex_flush_o(b_idf),
    .pc_redirect_o(b_rd), .pc_redirect_target_o(b_tgt)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles_o(b_pst), .perf_flush_count_o(b_pfl)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; mem_rd = 1'b0;
    redir = 1'b0; redir_tgt = 32'h0; busy = 1'b0;
  endtask

  task automatic load_use();
    mem_rd = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Reset: outputs forced to 0 even with active hazard inputs
    load_use(); redir = 1'b1; redir_tgt = 32'h0000_0040; busy = 1'b0;
    sample();
    chk("rst_str1", {25'd0, a_str}, {25'd0, NONE});
    chk("rst_str3", {25'd0, b_str}, {25'd0, NONE});
    chk("rst_tgt1", a_tgt, 32'h0);
    adv();
    idle();
    rst_n = 1'b1;
    sample();
    chk("idle_str1", {25'd0, a_str}, {25'd0, NONE});
    adv();

    // Load-use, single bubble (dut1) and three bubbles (dut3)
    load_use();
    sample();
    chk("lu_b1_d1", {25'd0, a_str}, {25'd0, BUB});
    chk("lu_b1_d3", {25'd0, b_str}, {25'd0, BUB});
    adv(); idle();
    sample();
    chk("lu_end_d1", {25'd0, a_str}, {25'd0, NONE});
    chk("lu_b2_d3", {25'd0, b_str}, {25'd0, BUB});
    adv(); sample();
    chk("lu_b3_d3", {25'd0, b_str}, {25'd0, BUB});
    adv(); sample();
    chk("lu_end_d3", {25'd0, b_str}, {25'd0, NONE});
    adv();

    // x0 destination and unused rs2 never stall
    mem_rd = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
    sample();
    chk("x0_d1", {25'd0, a_str}, {25'd0, NONE});
    adv();
    rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; rs2_used = 1'b0;
    sample();
    chk("rs2_unused_d1", {25'd0, a_str}, {25'd0, NONE});
    adv();
    rs2_used = 1'b1;
    sample();
    chk("rs2_used_d1", {25'd0, a_str}, {25'd0, BUB});
    adv(); idle(); adv(); adv();

    // Redirect beats load-use in the same cycle
    load_use(); redir = 1'b1; redir_tgt = 32'h0000_0040;
    sample();
    chk("rdr_str1", {25'd0, a_str}, {25'd0, RDR});
    chk("rdr_tgt1", a_tgt, 32'h0000_0040);
    chk("rdr_str3", {25'd0, b_str}, {25'd0, RDR});
    adv(); idle();
    sample();
    chk("rdr_after3", {25'd0, b_str}, {25'd0, NONE});
    chk("rdr_after_tgt", a_tgt, 32'h0);
    adv();

    // Busy for 3 cycles with redirect held pending; first redirect wins
    busy = 1'b1; redir = 1'b1; redir_tgt = 32'h0000_0080;
    sample();
    chk("bsy_c1", {25'd0, a_str}, {25'd0, BSY});
    chk("bsy_c1_tgt", a_tgt, 32'h0);
    adv(); redir_tgt = 32'h0000_00C0;
    sample();
    chk("bsy_c2", {25'd0, a_str}, {25'd0, BSY});
    adv(); redir = 1'b0;
    sample();
    chk("bsy_c3", {25'd0, b_str}, {25'd0, BSY});
    adv(); busy = 1'b0; redir = 1'b1; redir_tgt = 32'h0000_0100;
    sample();
    chk("bsy_rel_str", {25'd0, a_str}, {25'd0, RDR});
    chk("bsy_rel_tgt", a_tgt, 32'h0000_0080);
    adv(); idle();
    sample();
    chk("bsy_after", {25'd0, a_str}, {25'd0, NONE});
    adv();

    // LOAD_USE_CYCLES=3 with busy after bubble 2
    load_use();
    sample();
    chk("lub_b1", {25'd0, b_str}, {25'd0, BUB});
    adv(); idle();
    sample();
    chk("lub_b2", {25'd0, b_str}, {25'd0, BUB});
    adv(); busy = 1'b1;
    sample();
    chk("lub_bsy1", {25'd0, b_str}, {25'd0, BSY});
    adv();
    sample();
    chk("lub_bsy2", {25'd0, b_str}, {25'd0, BSY});
    adv(); busy = 1'b0;
    sample();
    chk("lub_b3", {25'd0, b_str}, {25'd0, BUB});
    chk("lub_rel_d1", {25'd0, a_str}, {25'd0, NONE});
    adv();
    sample();
    chk("lub_end", {25'd0, b_str}, {25'd0, NONE});
    adv();

    // Reset in the middle of LU_STALL
    load_use();
    sample();
    chk("rlu_b1", {25'd0, b_str}, {25'd0, BUB});
    adv(); idle();
    rst_n = 1'b0;
    sample();
    chk("rlu_rst3", {25'd0, b_str}, {25'd0, NONE});
`ifdef HAZARD_PERF_CNT_EN
    chk("rlu_pst3", b_pst, 32'h0);
    chk("rlu_pfl3", b_pfl, 32'h0);
    chk("rlu_pst1", a_pst, 32'h0);
`endif
    adv();
    rst_n = 1'b1;
    sample();
    chk("rlu_run3", {25'd0, b_str}, {25'd0, NONE});
    adv();
    load_use();
    sample();
    chk("rlu_new_b1", {25'd0, b_str}, {25'd0, BUB});
    adv(); idle();
`ifdef HAZARD_PERF_CNT_EN
    sample();
    chk("perf_stall3", b_pst, 32'd1);
    chk("perf_flush3", b_pfl, 32'd1);
`endif
    adv(); adv(); adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
